ldtu_bsl_calc: RTL and testbench
================================

LDTU_BSL_CALC -- requirements
Module: ldtu_bsl_calc

Interface
REQ-001 Parameter Nbits_12, default 12: ADC sample width.
REQ-002 Parameter Nbits_8, default 8: baseline value width.
REQ-003 Parameter N_SKIP, default 4: number of settling samples discarded after start.
REQ-004 Parameter REJ_THR, default 12'd1023: outlier rejection threshold, used only with the REQ-030 macro.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 DCLK  input  1: ADC data clock; all state on rising edge.
REQ-007 reset_  input  1: asynchronous active-low reset.
REQ-008 DATA12  input  Nbits_12: raw ADC sample, one per DCLK.
REQ-009 start  input  1: single-cycle request to begin a baseline measurement.
REQ-010 abort  input  1: synchronous cancel of a running measurement.
REQ-011 NSAMP_SEL  input  2: averaging length; 00=16, 01=32, 10=64, 11=128 samples.
REQ-012 BSL_VAL  output  Nbits_8: measured baseline, feeds the baseline-subtraction BSL_VAL port of the same gain channel.
REQ-013 bsl_valid  output  1: one-cycle pulse when BSL_VAL is updated.
REQ-014 busy  output  1: high while state is not IDLE.
REQ-015 sat  output  1: last result clipped to 255.
REQ-016 err  output  1: last measurement aborted by reject limit (REQ-030 only; tied 0 otherwise).

Function
REQ-017 FSM states IDLE, SKIP, ACCUM, DONE; busy SHALL equal (state != IDLE), decoded from registered state.
REQ-018 IDLE: start=1 at an edge SHALL clear accumulator, sample counter and reject counter, latch NSAMP_SEL, and move to SKIP; NSAMP_SEL changes after acceptance SHALL be ignored.
REQ-019 SKIP: discard N_SKIP consecutive samples, then move to ACCUM; N_SKIP=0 SHALL go straight to ACCUM.
REQ-020 ACCUM: each edge adds zero-extended DATA12 to a 19-bit accumulator and increments the sample counter; the edge accumulating sample N moves to DONE.
REQ-021 Accumulator SHALL be 19 bits unsigned (128*4095 = 524160 fits without wrap).
REQ-022 Mean = accumulator >> log2(N) (truncation, no rounding); if mean > 255, BSL_VAL <= 8'hFF and sat <= 1, else BSL_VAL <= mean[7:0] and sat <= 0.
REQ-023 Latency: last sample captured at edge E; BSL_VAL and sat load and bsl_valid rises at E+1 (DONE); bsl_valid falls and FSM enters IDLE at E+2.
REQ-024 BSL_VAL, sat, err SHALL hold between measurements; BSL_VAL is never updated mid-measurement.
REQ-025 start while busy (SKIP, ACCUM, DONE) SHALL be ignored; start at edge E+2 (IDLE re-entry edge) SHALL be ignored, and start is accepted from E+3.
REQ-026 abort=1 in SKIP or ACCUM SHALL return to IDLE at that edge with no bsl_valid and BSL_VAL, sat, err unchanged; abort in IDLE or DONE has no effect; abort wins over start at the same edge.

Reset
REQ-027 reset_=0 SHALL asynchronously force state=IDLE, BSL_VAL=0, bsl_valid=0, busy=0, sat=0, err=0, and all counters and the accumulator to 0.
REQ-028 Reset mid-measurement SHALL discard the partial sum; after release, the block waits for a new start.
REQ-029 Reset deassertion is synchronized externally; the block takes no action before the first start.

Configuration
REQ-030 Macro LDTU_BSL_OUTLIER_REJECT_EN defined: in ACCUM, a sample with DATA12 > REJ_THR SHALL NOT be accumulated or counted; it increments an 8-bit reject counter; when the reject counter reaches 255, the FSM SHALL go to DONE with err=1, bsl_valid pulsed, and BSL_VAL and sat unchanged; a normal completion sets err=0.
REQ-031 Macro undefined: every ACCUM sample is accumulated, no reject counter exists, err is tied to 0, and REJ_THR is unused.

Verification
REQ-032 NSAMP_SEL=00, DATA12 constant 12'd100, start pulse -> bsl_valid at edge 21 after the start edge, BSL_VAL=100, sat=0, busy low at edge 22.
REQ-033 NSAMP_SEL=11, DATA12 alternating 12'd50/12'd51 -> BSL_VAL=50 (truncation); DATA12=12'd4095 constant -> BSL_VAL=255, sat=1.
REQ-034 abort at 10th ACCUM sample after a prior BSL_VAL=100 -> busy drops next edge, no bsl_valid, BSL_VAL stays 100; reset_ pulse mid-ACCUM -> all outputs 0 immediately.
REQ-035 start held high for 40 cycles with NSAMP_SEL=00 -> exactly one measurement accepted during busy; repeated start pulses in ACCUM produce no extra bsl_valid.
REQ-036 With LDTU_BSL_OUTLIER_REJECT_EN: 16 samples of 12'd200 interleaved with 12'd3000 spikes -> BSL_VAL=200, err=0; constant 12'd3000 -> err=1 after 255 rejects, BSL_VAL unchanged.

Source files
------------

// File: rtl/ldtu_bsl_calc.sv
// Baseline calculator: averages 16..128 ADC samples after a settling skip and publishes an 8-bit baseline.
// Optional outlier rejection is enabled with `define LDTU_BSL_OUTLIER_REJECT_EN.
module ldtu_bsl_calc #(
    parameter int unsigned Nbits_12 = 12,
    parameter int unsigned Nbits_8  = 8,
    parameter int unsigned N_SKIP   = 4,
    parameter int unsigned REJ_THR  = 1023
) (
    input  logic                DCLK,
    input  logic                reset_,
    input  logic [Nbits_12-1:0] DATA12,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          NSAMP_SEL,
    output logic [Nbits_8-1:0]  BSL_VAL,
    output logic                bsl_valid,
    output logic                busy,
    output logic                sat,
    output logic                err
);

    localparam int unsigned ACC_W     = Nbits_12 + 7;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned SKIP_W    = (N_SKIP > 1) ? $clog2(N_SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((N_SKIP > 0) ? N_SKIP - 1 : 0);
    localparam logic [ACC_W-1:0]  MEAN_MAX  = ACC_W'((1 << Nbits_8) - 1);

    // A threshold above the sample range could never reject anything
    if (REJ_THR >= (1 << Nbits_12)) begin : g_rej_thr_range
        $error("REJ_THR exceeds the DATA12 range");
    end

    typedef enum logic [1:0] {IDLE, SKIP, ACCUM, DONE} state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SKIP_W-1:0]   skip_q;
    logic [1:0]          nsel_q;
    logic [2:0]          shift_c;
    logic [ACC_W-1:0]    mean_c;
    logic [CNT_W-1:0]    target_c;
    logic                reject_c;

    assign busy     = (state != IDLE);
    assign shift_c  = 3'd4 + {1'b0, nsel_q};
    assign mean_c   = acc_q >> shift_c;
    assign target_c = CNT_W'(16) << nsel_q;

`ifdef LDTU_BSL_OUTLIER_REJECT_EN
    logic [7:0] rej_q;
    assign reject_c = (DATA12 > Nbits_12'(REJ_THR));
`else
    assign reject_c = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge DCLK or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            skip_q    <= '0;
            nsel_q    <= '0;
            BSL_VAL   <= '0;
            bsl_valid <= 1'b0;
            sat       <= 1'b0;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
            rej_q     <= '0;
            err       <= 1'b0;
`endif
        end else begin
            bsl_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        skip_q <= '0;
                        nsel_q <= NSAMP_SEL;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
                        rej_q  <= '0;
`endif
                        state  <= (N_SKIP == 0) ? ACCUM : SKIP;
                    end
                end
                SKIP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (skip_q == SKIP_LAST) begin
                        state <= ACCUM;
                    end else begin
                        skip_q <= SKIP_W'(skip_q + 1'b1);
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (reject_c) begin
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
                        rej_q <= rej_q + 8'd1;
                        if (rej_q == 8'hFE) begin
                            state <= DONE;
                        end
`endif
                    end else begin
                        acc_q <= acc_q + ACC_W'(DATA12);
                        cnt_q <= CNT_W'(cnt_q + 1'b1);
                        if (CNT_W'(cnt_q + 1'b1) == target_c) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; second returns to IDLE
                    if (!bsl_valid) begin
                        bsl_valid <= 1'b1;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
                        err <= (rej_q == 8'hFF);
                        if (rej_q != 8'hFF) begin
                            BSL_VAL <= (mean_c > MEAN_MAX) ? '1 : Nbits_8'(mean_c);
                            sat     <= (mean_c > MEAN_MAX);
                        end
`else
                        BSL_VAL <= (mean_c > MEAN_MAX) ? '1 : Nbits_8'(mean_c);
                        sat     <= (mean_c > MEAN_MAX);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldtu_bsl_calc.sv
// Directed scoreboard bench for ldtu_bsl_calc; outlier cases run when LDTU_BSL_OUTLIER_REJECT_EN is defined.
module tb_ldtu_bsl_calc;

    localparam int unsigned NSKIP = 4;
    localparam int unsigned RTHR  = 1023;
`ifdef LDTU_BSL_OUTLIER_REJECT_EN
    localparam bit REJ_ON = 1'b1;
`else
    localparam bit REJ_ON = 1'b0;
`endif

    logic        DCLK = 1'b0;
    logic        reset_;
    logic [11:0] DATA12;
    logic        start;
    logic        abort;
    logic [1:0]  NSAMP_SEL;
    logic [7:0]  BSL_VAL;
    logic        bsl_valid;
    logic        busy;
    logic        sat;
    logic        err;

    always #5 DCLK = ~DCLK;

    ldtu_bsl_calc #(
        .Nbits_12(12),
        .Nbits_8 (8),
        .N_SKIP  (NSKIP),
        .REJ_THR (RTHR)
    ) dut (
        .DCLK     (DCLK),
        .reset_   (reset_),
        .DATA12   (DATA12),
        .start    (start),
        .abort    (abort),
        .NSAMP_SEL(NSAMP_SEL),
        .BSL_VAL  (BSL_VAL),
        .bsl_valid(bsl_valid),
        .busy     (busy),
        .sat      (sat),
        .err      (err)
    );

    typedef struct {
        logic [7:0] val;
        logic       sat;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_val;
    logic       m_sat;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge DCLK);
        @(negedge DCLK);
    endtask

    // Sample driven k cycles after the start edge (k=0 is the start edge itself)
    function automatic logic [11:0] pat(input int mode, input logic [11:0] v, input int k);
        case (mode)
            1:       return v + 12'(k & 1);
            2:       return (k % 2 == 0) ? v : 12'd3000;
            default: return v;
        endcase
    endfunction

    task automatic predict(input logic [1:0] sel, input int mode, input logic [11:0] v, output exp_t e);
        int n, acc, sum, rej, mean;
        logic [11:0] d;
        logic [31:0] mv;
        n = 16 << sel;
        acc = 0; sum = 0; rej = 0;
        e.lat = -1; e.val = m_val; e.sat = m_sat; e.err = m_err;
        for (int k = NSKIP + 1; k < 4000 && e.lat < 0; k++) begin
            d = pat(mode, v, k);
            if (REJ_ON && (d > RTHR)) begin
                rej++;
                if (rej == 255) begin
                    e.lat = k + 1;
                    e.err = 1'b1;
                end
            end else begin
                sum += int'(d);
                acc++;
                if (acc == n) begin
                    mean  = sum >> (4 + int'(sel));
                    mv    = 32'(mean);
                    e.sat = (mean > 255);
                    e.val = e.sat ? 8'hFF : mv[7:0];
                    e.err = 1'b0;
                    e.lat = k + 1;
                end
            end
        end
    endtask

    task automatic run_meas(input string tag, input logic [1:0] sel, input int mode,
                            input logic [11:0] v, input int abort_k, input bit pulse);
        exp_t e, got;
        int   last, nvalid;
        if (abort_k == 0) begin
            predict(sel, mode, v, e);
            sb.push_back(e);
            m_val = e.val; m_sat = e.sat; m_err = e.err;
            last  = e.lat + 1;
        end else begin
            last  = abort_k + 6;
        end
        NSAMP_SEL = sel;
        start     = 1'b1;
        DATA12    = pat(mode, v, 0);
        tick();
        start     = 1'b0;
        NSAMP_SEL = ~sel;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'(1));
        nvalid = 0;
        for (int k = 1; k <= last; k++) begin
            DATA12 = pat(mode, v, k);
            abort  = (k == abort_k);
            start  = pulse && (k >= int'(NSKIP) + 2) && (k % 3 == 0) && (k < last - 3);
            tick();
            abort  = 1'b0;
            start  = 1'b0;
            if (k == abort_k) begin
                chk({tag, "_busy_after_abort"}, 32'(busy), 32'(0));
                chk({tag, "_bsl_held"}, 32'(BSL_VAL), 32'(m_val));
            end
            if (bsl_valid) begin
                nvalid++;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk({tag, "_latency"}, 32'(k), 32'(got.lat));
                    chk({tag, "_bsl_val"}, 32'(BSL_VAL), 32'(got.val));
                    chk({tag, "_sat"}, 32'(sat), 32'(got.sat));
                    chk({tag, "_err"}, 32'(err), 32'(got.err));
                end
            end
        end
        chk({tag, "_valid_count"}, 32'(nvalid), (abort_k == 0) ? 32'(1) : 32'(0));
        chk({tag, "_idle_at_end"}, 32'(busy), 32'(0));
        chk({tag, "_pending"}, 32'(sb.size()), 32'(0));
        repeat (2) tick();
    endtask

    initial begin
        exp_t e, got;
        int   nvalid, pos0, pos1;

        reset_ = 1'b0; DATA12 = '0; start = 1'b0; abort = 1'b0; NSAMP_SEL = 2'b00;
        m_val = '0; m_sat = 1'b0; m_err = 1'b0;
        repeat (2) tick();
        chk("rst_bsl_val", 32'(BSL_VAL), 32'(0));
        chk("rst_valid", 32'(bsl_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_sat", 32'(sat), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        reset_ = 1'b1;
        repeat (3) tick();
        chk("idle_no_start", 32'(busy), 32'(0));

        run_meas("m16_c100", 2'b00, 0, 12'd100, 0, 1'b0);
        run_meas("abort_acc10", 2'b00, 0, 12'd77, int'(NSKIP) + 10, 1'b0);
        run_meas("m128_alt50", 2'b11, 1, 12'd50, 0, 1'b0);
        run_meas("m128_c4095", 2'b11, 0, 12'd4095, 0, 1'b0);
        run_meas("m32_alt37_pulse", 2'b01, 1, 12'd37, 0, 1'b1);
        run_meas("m64_c255", 2'b10, 0, 12'd255, 0, 1'b0);
        run_meas("m16_c256", 2'b00, 0, 12'd256, 0, 1'b0);

        // Reset in the middle of an accumulation
        NSAMP_SEL = 2'b00; DATA12 = 12'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #1 reset_ = 1'b0;
        #1;
        chk("midrst_bsl_val", 32'(BSL_VAL), 32'(0));
        chk("midrst_sat", 32'(sat), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_valid", 32'(bsl_valid), 32'(0));
        chk("midrst_err", 32'(err), 32'(0));
        tick();
        reset_ = 1'b1;
        m_val = '0; m_sat = 1'b0; m_err = 1'b0;
        repeat (5) tick();
        chk("postrst_busy", 32'(busy), 32'(0));
        chk("postrst_bsl_val", 32'(BSL_VAL), 32'(0));

        run_meas("m32_c100", 2'b01, 0, 12'd100, 0, 1'b0);

        // Start held for 40 cycles: second acceptance only after IDLE re-entry
        predict(2'b00, 0, 12'd100, e);
        sb.push_back(e);
        sb.push_back(e);
        nvalid = 0; pos0 = -1; pos1 = -1;
        NSAMP_SEL = 2'b00; DATA12 = 12'd100;
        for (int k = 0; k < 70; k++) begin
            start = (k < 40);
            tick();
            if (k == 22) chk("held_idle_gap", 32'(busy), 32'(0));
            if (k == 23) chk("held_reaccept", 32'(busy), 32'(1));
            if (bsl_valid) begin
                if (nvalid == 0) pos0 = k; else pos1 = k;
                nvalid++;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk("held_bsl_val", 32'(BSL_VAL), 32'(got.val));
                end
            end
        end
        start = 1'b0;
        chk("held_valid_count", 32'(nvalid), 32'(2));
        chk("held_first_pos", 32'(pos0), 32'(21));
        chk("held_second_pos", 32'(pos1), 32'(44));
        sb.delete();
        m_val = e.val; m_sat = e.sat; m_err = e.err;
        repeat (3) tick();

`ifdef LDTU_BSL_OUTLIER_REJECT_EN
        run_meas("rej_interleave200", 2'b00, 2, 12'd200, 0, 1'b0);
        run_meas("rej_c3000", 2'b00, 0, 12'd3000, 0, 1'b0);
        run_meas("rej_recover", 2'b00, 0, 12'd100, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
